// File: rtl/cubehash_pkg.sv
// cubehash_pkg -- shared definitions for the CubeHash control slice.
//   BLK_W / STATE_W : message block and permutation state widths
//   DEF_ROUNDS / DEF_FIN_ROUNDS : default round counts
//   state_t + ST_* : controller FSM encoding
//   max2()         : helper for sizing the round counter
package cubehash_pkg;

  localparam int BLK_W          = 256;
  localparam int STATE_W        = 1024;
  localparam int DEF_ROUNDS     = 16;
  localparam int DEF_FIN_ROUNDS = 160;

  typedef logic [2:0] state_t;
  localparam state_t ST_PRIME = 3'd0;
  localparam state_t ST_WAIT  = 3'd1;
  localparam state_t ST_ROUND = 3'd2;
  localparam state_t ST_FINAL = 3'd3;
  localparam state_t ST_OUT   = 3'd4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cubehash_round_cnt.sv
// cubehash_round_cnt -- loadable down counter for round sequencing.
//   clk, rst_n    : clock, async active-low reset (count -> 0)
//   load_i        : load load_val_i (wins over en_i)
//   load_val_i    : value loaded
//   en_i          : decrement, stops at zero
//   cnt_o         : current count
//   tc_o          : terminal count (count == 0)
module cubehash_round_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt_q <= '0;
    else if (load_i)              cnt_q <= load_val_i;
    else if (en_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == '0);

endmodule

// File: rtl/cubehash_ctrl.sv
// cubehash_ctrl -- sequencing FSM for a CubeHash datapath.
//   clk, rst_n      : clock, async active-low reset
//   blk_valid/blk_ready/blk_last/msg_in : message block handshake
//   hold            : freezes the FSM and the datapath
//   msg, done, xor_fin, out_en, start1, in_en, stop_process : datapath controls
//   hash_valid      : one-cycle pulse after the hash register is loaded
//   blk_cnt         : blocks accepted in the current message
// Optional macro CUBEHASH_CTRL_STAT_EN enables the blk_cnt counter; without
// it blk_cnt reads 0.
// ROUNDS must be >= 2: a non-last block gets ROUNDS-1 ROUND cycles because the
// accepting WAIT_BLK cycle already runs one round.
module cubehash_ctrl
  import cubehash_pkg::*;
#(
  parameter int ROUNDS     = DEF_ROUNDS,
  parameter int FIN_ROUNDS = DEF_FIN_ROUNDS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             blk_valid,
  input  logic             blk_last,
  input  logic [BLK_W-1:0] msg_in,
  input  logic             hold,
  output logic             blk_ready,
  output logic [BLK_W-1:0] msg,
  output logic             done,
  output logic             xor_fin,
  output logic             out_en,
  output logic             start1,
  output logic             in_en,
  output logic             stop_process,
  output logic             hash_valid,
  output logic [15:0]      blk_cnt
);

  localparam int CW = $clog2(max2(ROUNDS, FIN_ROUNDS) + 1);

  state_t        state_q, state_d;
  logic          first_q, first_d;
  logic          last_q, last_d;
  logic          hv_q, hv_d;
  logic          cnt_load, cnt_en, cnt_tc;
  logic [CW-1:0] cnt_val, cnt;
  logic          adv, accept;

  assign adv    = ~hold;
  assign accept = (state_q == ST_WAIT) && blk_valid && adv;

  cubehash_round_cnt #(.W(CW)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .cnt_o      (cnt),
    .tc_o       (cnt_tc)
  );

  always_comb begin
    state_d      = state_q;
    first_d      = first_q;
    last_d       = last_q;
    cnt_load     = 1'b0;
    cnt_val      = '0;
    cnt_en       = 1'b0;
    blk_ready    = 1'b0;
    msg          = '0;
    done         = 1'b0;
    xor_fin      = 1'b0;
    out_en       = 1'b0;
    start1       = 1'b0;
    in_en        = 1'b0;
    stop_process = 1'b1;
    case (state_q)
      ST_PRIME: begin
        in_en  = 1'b1;
        start1 = 1'b1;
        if (adv) begin
          state_d = ST_WAIT;
          first_d = 1'b1;
        end
      end
      ST_WAIT: begin
        blk_ready    = adv;
        in_en        = 1'b1;
        msg          = msg_in;
        done         = blk_valid & adv;
        stop_process = ~blk_valid | hold;
        start1       = first_q & ~blk_valid;
        if (accept) begin
          first_d  = 1'b0;
          last_d   = blk_last;
          cnt_load = 1'b1;
          cnt_val  = blk_last ? CW'(ROUNDS - 1) : CW'(ROUNDS - 2);
          state_d  = ST_ROUND;
        end
      end
      ST_ROUND: begin
        stop_process = hold;
        if (adv) begin
          if (!cnt_tc) cnt_en = 1'b1;
          else if (last_q) begin
            state_d  = ST_FINAL;
            cnt_load = 1'b1;
            cnt_val  = CW'(FIN_ROUNDS - 1);
          end else state_d = ST_WAIT;
        end
      end
      ST_FINAL: begin
        stop_process = hold;
        // Counter is frozen while held, so the first advancing cycle is
        // the one still sitting at the load value.
        xor_fin = adv && (cnt == CW'(FIN_ROUNDS - 1));
        if (adv) begin
          if (!cnt_tc) cnt_en = 1'b1;
          else         state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        out_en = adv;
        if (adv) state_d = ST_PRIME;
      end
      default: state_d = ST_PRIME;
    endcase
  end

  assign hv_d = (state_q == ST_OUT) && adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PRIME;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      hv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      last_q  <= last_d;
      hv_q    <= hv_d;
    end
  end

  assign hash_valid = hv_q;

`ifdef CUBEHASH_CTRL_STAT_EN
  logic [15:0] blk_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        blk_cnt_q <= '0;
    else if (state_d == ST_PRIME && state_q != ST_PRIME) blk_cnt_q <= '0;
    else if (accept && blk_cnt_q != 16'hFFFF)          blk_cnt_q <= blk_cnt_q + 16'd1;
  end
  assign blk_cnt = blk_cnt_q;
`else
  assign blk_cnt = '0;
`endif

endmodule

// File: tb/tb_cubehash_ctrl.sv
// tb_cubehash_ctrl -- directed cycle-accurate checks of cubehash_ctrl.
// Cycle 0 is the first cycle after rst_n rises; outputs are sampled on the
// falling edge, inputs change 1 time unit after the rising edge.
module tb_cubehash_ctrl;
  import cubehash_pkg::*;

`ifdef CUBEHASH_CTRL_STAT_EN
  localparam int STAT = 1;
`else
  localparam int STAT = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             blk_valid = 1'b0, blk_last = 1'b0, hold = 1'b0;
  logic [BLK_W-1:0] msg_in = '0;
  logic             blk_ready, done, xor_fin, out_en, start1, in_en, stop_process, hash_valid;
  logic [BLK_W-1:0] msg;
  logic [15:0]      blk_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cubehash_ctrl dut (
    .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid), .blk_last(blk_last),
    .msg_in(msg_in), .hold(hold), .blk_ready(blk_ready), .msg(msg), .done(done),
    .xor_fin(xor_fin), .out_en(out_en), .start1(start1), .in_en(in_en),
    .stop_process(stop_process), .hash_valid(hash_valid), .blk_cnt(blk_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Controls expected in PRIME: in_en,start1,stop_process,done,xor_fin,out_en,blk_ready
  function automatic logic [6:0] ctl();
    return {in_en, start1, stop_process, done, xor_fin, out_en, blk_ready};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; blk_valid = 1'b0; blk_last = 1'b0; hold = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Runs one message from cycle 0. avail2: first cycle block 2 is offered.
  // hs/hl: hold window. abort_c: cycle at which reset is asserted (-1 none).
  task automatic run_msg(input string nm, input int nblk, input int avail2,
                         input int hs, input int hl, input int abort_c,
                         input int e_acc1, input int e_acc2, input int e_xor,
                         input int e_out);
    int sent = 0;
    int acc1 = -1, acc2 = -1, xor_c = -1, xor_n = 0, out_c = -1, out_n = 0;
    int hv_c = -1, hold_bad = 0, xor_hold = 0, stop_n = 0, msg_bad = 0, cnt_out = -1;
    logic [31:0] w;
    for (int c = 0; c < 400; c++) begin
      blk_valid = (sent < nblk) && (sent == 0 || c >= avail2);
      blk_last  = (sent == nblk - 1);
      w = 32'hA5C30000 + 32'(sent * 17 + 3);
      msg_in = {8{w}};
      hold = (c >= hs) && (c < hs + hl);
      if (c == abort_c) begin
        rst_n = 1'b0;
        #1;
        chk({nm, ":abort_ctl"}, 64'(ctl()), 64'b1110000);
        chk({nm, ":abort_hv"}, 64'(hash_valid), 64'd0);
        chk({nm, ":abort_cnt"}, 64'(blk_cnt), 64'd0);
        chk({nm, ":abort_no_out"}, 64'(out_n), 64'd0);
        return;
      end
      #4;
      if (c == 0) begin
        chk({nm, ":rst_ctl"}, 64'(ctl()), 64'b1110000);
        chk({nm, ":rst_hv"}, 64'(hash_valid), 64'd0);
        chk({nm, ":rst_cnt"}, 64'(blk_cnt), 64'd0);
      end
      if (blk_valid && blk_ready) begin
        if (msg !== msg_in || !done || stop_process) msg_bad++;
        if (sent == 0) acc1 = c; else acc2 = c;
        sent++;
      end
      if (xor_fin) begin if (xor_c < 0) xor_c = c; xor_n++; if (hold) xor_hold++; end
      if (out_en)  begin if (out_c < 0) out_c = c; out_n++; cnt_out = int'(blk_cnt); end
      if (hold && (done || out_en || blk_ready || !stop_process)) hold_bad++;
      if (c >= 17 && c <= 26 && stop_process) stop_n++;
      if (hash_valid) begin
        hv_c = c;
        chk({nm, ":prime_ctl"}, 64'(ctl()), 64'b1110000);
        chk({nm, ":prime_cnt"}, 64'(blk_cnt), 64'd0);
        break;
      end
      @(posedge clk);
      #1;
    end
    chk({nm, ":acc1"}, 64'(acc1), 64'(e_acc1));
    if (nblk > 1) chk({nm, ":acc2"}, 64'(acc2), 64'(e_acc2));
    chk({nm, ":msg"}, 64'(msg_bad), 64'd0);
    chk({nm, ":xor_c"}, 64'(xor_c), 64'(e_xor));
    chk({nm, ":xor_n"}, 64'(xor_n), 64'd1);
    chk({nm, ":out_c"}, 64'(out_c), 64'(e_out));
    chk({nm, ":out_n"}, 64'(out_n), 64'd1);
    chk({nm, ":hv_c"}, 64'(hv_c), 64'(e_out + 1));
    chk({nm, ":cnt_out"}, 64'(cnt_out), 64'(STAT * nblk));
    if (hl > 0) begin
      chk({nm, ":hold_bad"}, 64'(hold_bad), 64'd0);
      chk({nm, ":xor_hold"}, 64'(xor_hold), 64'd0);
    end
    if (avail2 > 17) chk({nm, ":stop_gap"}, 64'(stop_n), 64'd10);
  endtask

  initial begin
    do_reset();
    run_msg("one",   1, 0,  -1, 0, -1,  1, -1, 18, 178);
    do_reset();
    run_msg("two",   2, 0,  -1, 0, -1,  1, 17, 34, 194);
    do_reset();
    run_msg("gap",   2, 27, -1, 0, -1,  1, 27, 44, 204);
    do_reset();
    run_msg("hold",  1, 0,  18, 5, -1,  1, -1, 23, 183);
    do_reset();
    run_msg("abort", 1, 0,  -1, 0, 100, 1, -1, 18, 178);
    // reset still low: nothing may emerge for the abandoned message
    repeat (3) begin
      @(negedge clk);
      chk("abort:hold_rst", 64'({out_en, hash_valid}), 64'd0);
    end
    do_reset();
    run_msg("after", 1, 0,  -1, 0, -1,  1, -1, 18, 178);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
